// File: rtl/im_loader.sv
// ============================================================================
// Module   : im_loader
// Brief    : Receives a byte-serial program image (16-bit big-endian word
//            count followed by big-endian 32-bit words), writes each word to
//            instruction memory, and releases the CPU once the image is
//            complete. An inter-byte timeout and an oversize count abort
//            the load.
//            Optional macro IM_LOADER_CHECKSUM_EN: a trailing byte holding
//            the 8-bit sum of all data bytes must match before the CPU is
//            released.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module im_loader #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 1000000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Rx_valid,
    input  logic [7:0]        Rx_data,
    output logic              IM_we,
    output logic [ADDR_W-1:0] IM_addr,
    output logic [31:0]       IM_wdata,
    output logic              CPU_run,
    output logic              Done,
    output logic              Err
);

    // Idle counter only needs to reach TIMEOUT-1; the abort fires on the
    // idle cycle that would make it TIMEOUT.
    localparam int                c_TO_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST   = c_TO_W'(TIMEOUT - 1);
    localparam logic [31:0]       c_MAX_WORDS = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_LO = 3'd1,
        S_LOAD   = 3'd2,
        S_DONE   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t              r_state;
    logic [15:0]         r_count;     // word count N; high byte valid after IDLE
    logic [ADDR_W:0]     r_word_idx;  // one extra bit so N = 2^ADDR_W never aliases
    logic [1:0]          r_byte_idx;
    logic [31:0]         r_asm;
    logic [c_TO_W-1:0]   r_idle_cnt;
`ifdef IM_LOADER_CHECKSUM_EN
    logic [7:0]          r_csum;
`endif

    logic [15:0] w_n;
    logic [31:0] w_word;
    logic        w_all_words;
    logic        w_timeout;
    logic        w_too_big;
    logic        w_finish;
    logic        w_csum_phase;
    logic        w_csum_ok;

    assign w_n         = {r_count[15:8], Rx_data};
    assign w_word      = {r_asm[23:0], Rx_data};
    assign w_all_words = (32'(r_word_idx) == 32'(r_count));
    assign w_timeout   = !Rx_valid && (r_idle_cnt == c_TO_LAST);
    assign w_too_big   = ({16'd0, w_n} > c_MAX_WORDS);

`ifdef IM_LOADER_CHECKSUM_EN
    // Once every word has been received, the next byte is the checksum.
    // It may legally arrive during the final write cycle.
    assign w_finish     = 1'b0;
    assign w_csum_phase = w_all_words;
    assign w_csum_ok    = (Rx_data == r_csum);
`else
    // Without a checksum the load ends as the final write cycle completes.
    assign w_finish     = IM_we && w_all_words;
    assign w_csum_phase = 1'b0;
    assign w_csum_ok    = 1'b0;
`endif

    // Loader state machine with registered memory-write and status outputs
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= S_IDLE;
            r_count    <= 16'd0;
            r_word_idx <= '0;
            r_byte_idx <= 2'd0;
            r_asm      <= 32'd0;
            r_idle_cnt <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
            r_csum     <= 8'd0;
`endif
            IM_we      <= 1'b0;
            IM_addr    <= '0;
            IM_wdata   <= 32'd0;
            CPU_run    <= 1'b0;
            Done       <= 1'b0;
            Err        <= 1'b0;
        end else begin
            // The write strobe is a single-cycle pulse unless re-armed below
            IM_we <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (Rx_valid) begin
                        r_count    <= {Rx_data, 8'h00};
                        r_idle_cnt <= '0;
                        r_state    <= S_CNT_LO;
                    end
                end

                S_CNT_LO: begin
                    if (Rx_valid) begin
                        r_count    <= w_n;
                        r_word_idx <= '0;
                        r_byte_idx <= 2'd0;
                        r_asm      <= 32'd0;
                        r_idle_cnt <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
                        r_csum     <= 8'd0;
`endif
                        if (w_too_big) begin
                            r_state <= S_ERR;
                            Err     <= 1'b1;
`ifndef IM_LOADER_CHECKSUM_EN
                        end else if (w_n == 16'd0) begin
                            r_state <= S_DONE;
                            Done    <= 1'b1;
                            CPU_run <= 1'b1;
`endif
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end else if (w_timeout) begin
                        r_state <= S_ERR;
                        Err     <= 1'b1;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + c_TO_W'(1);
                    end
                end

                S_LOAD: begin
                    if (w_finish) begin
                        r_state <= S_DONE;
                        Done    <= 1'b1;
                        CPU_run <= 1'b1;
                    end else if (Rx_valid && w_csum_phase) begin
                        if (w_csum_ok) begin
                            r_state <= S_DONE;
                            Done    <= 1'b1;
                            CPU_run <= 1'b1;
                        end else begin
                            r_state <= S_ERR;
                            Err     <= 1'b1;
                        end
                    end else if (Rx_valid) begin
                        r_idle_cnt <= '0;
                        r_asm      <= w_word;
                        r_byte_idx <= r_byte_idx + 2'd1;
`ifdef IM_LOADER_CHECKSUM_EN
                        r_csum     <= r_csum + Rx_data;
`endif
                        // Fourth byte completes a word: write it next cycle
                        if (r_byte_idx == 2'd3) begin
                            IM_we      <= 1'b1;
                            IM_addr    <= r_word_idx[ADDR_W-1:0];
                            IM_wdata   <= w_word;
                            r_word_idx <= r_word_idx + (ADDR_W+1)'(1);
                        end
                    end else if (w_timeout) begin
                        r_state <= S_ERR;
                        Err     <= 1'b1;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + c_TO_W'(1);
                    end
                end

                // Terminal states: bytes are ignored, only reset leaves
                S_DONE: r_state <= S_DONE;
                S_ERR:  r_state <= S_ERR;

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_im_loader.sv
// ============================================================================
// Module   : tb_im_loader
// Brief    : Self-checking bench for im_loader: table vectors, randomized
//            streams against a stream-level reference model, and directed
//            timeout / reset / boundary sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_im_loader;

    localparam int AW = 10;
    localparam int TO = 20;
    localparam int NV = 7;

    logic            Clk;
    logic            Reset;
    logic            Rx_valid;
    logic [7:0]      Rx_data;
    logic            IM_we;
    logic [AW-1:0]   IM_addr;
    logic [31:0]     IM_wdata;
    logic            CPU_run;
    logic            Done;
    logic            Err;

    im_loader #(
        .ADDR_W  (AW),
        .TIMEOUT (TO)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Rx_valid (Rx_valid),
        .Rx_data  (Rx_data),
        .IM_we    (IM_we),
        .IM_addr  (IM_addr),
        .IM_wdata (IM_wdata),
        .CPU_run  (CPU_run),
        .Done     (Done),
        .Err      (Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int          len;
        logic [7:0]  b [12];
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          done;
        bit          err;
    } vec_t;

    int         checks   = 0;
    int         failures = 0;
    wr_t        wr_q [$];
    wr_t        exp_q [$];
    logic [7:0] stim [$];
    bit         exp_done;
    bit         exp_err;
    vec_t       vt [NV];

    // Record every memory write seen, away from the active edge
    always @(negedge Clk) begin
        if (IM_we) wr_q.push_back('{int'(IM_addr), IM_wdata});
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        Rx_valid = 1'b1;
        Rx_data  = b;
        @(negedge Clk);
        Rx_valid = 1'b0;
    endtask

    task automatic send_stim(input int gapmax);
        foreach (stim[i]) begin
            send_byte(stim[i]);
            if (gapmax > 0) idle($urandom_range(0, gapmax));
        end
    endtask

    task automatic do_reset();
        #2 Reset = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        wr_q.delete();
    endtask

    // Insert the correct checksum byte right after the data bytes
    task automatic fixup_csum();
`ifdef IM_LOADER_CHECKSUM_EN
        int         n;
        logic [7:0] s;
        if (stim.size() < 2) return;
        n = int'({stim[0], stim[1]});
        if (n > (1 << AW) || stim.size() < 2 + 4 * n) return;
        s = 8'h00;
        for (int i = 0; i < 4 * n; i++) s = s + stim[2 + i];
        stim.insert(2 + 4 * n, s);
`endif
    endtask

    // Reference: expected writes and final status from the byte stream alone
    task automatic model_stream();
        int         n;
        int         avail;
        logic [7:0] s;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        s = 8'h00;
        if (stim.size() < 2) return;
        n = int'({stim[0], stim[1]});
        if (n > (1 << AW)) begin
            exp_err = 1'b1;
            return;
        end
        avail = stim.size() - 2;
        for (int w = 0; w < n && 4 * w + 3 < avail; w++)
            exp_q.push_back('{w, {stim[2+4*w], stim[3+4*w], stim[4+4*w], stim[5+4*w]}});
`ifdef IM_LOADER_CHECKSUM_EN
        if (avail >= 4 * n + 1) begin
            for (int i = 0; i < 4 * n; i++) s = s + stim[2 + i];
            exp_done = (s == stim[2 + 4 * n]);
            exp_err  = !exp_done;
        end
`else
        exp_done = (avail >= 4 * n);
`endif
    endtask

    task automatic check_writes(input string nm);
        chk({nm, " nwr"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            chk($sformatf("%s w%0d addr", nm, i), wr_q[i].addr, exp_q[i].addr);
            chk($sformatf("%s w%0d data", nm, i), wr_q[i].data, exp_q[i].data);
        end
    endtask

    task automatic check_status(input string nm, input bit d, input bit e);
        chk({nm, " Done"},    Done,    d);
        chk({nm, " Err"},     Err,     e);
        chk({nm, " CPU_run"}, CPU_run, d);
    endtask

    initial begin
        int n;
        int z;

        vt[0] = '{10, '{8'h00,8'h02,8'h12,8'h34,8'h56,8'h78,8'hAA,8'hBB,8'hCC,8'hDD,8'h00,8'h00},
                  2, 32'h12345678, 32'hAABBCCDD, 1'b1, 1'b0};
        vt[1] = '{2,  '{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                  0, 32'h0, 32'h0, 1'b1, 1'b0};
        vt[2] = '{8,  '{8'h04,8'h01,8'h00,8'h01,8'h11,8'h22,8'h33,8'h44,8'h00,8'h00,8'h00,8'h00},
                  0, 32'h0, 32'h0, 1'b0, 1'b1};
        vt[3] = '{6,  '{8'h00,8'h01,8'hDE,8'hAD,8'hBE,8'hEF,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                  1, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0};
        vt[4] = '{10, '{8'h00,8'h01,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08,8'h00,8'h00},
                  1, 32'h01020304, 32'h0, 1'b1, 1'b0};
        vt[5] = '{4,  '{8'h00,8'h00,8'hAA,8'hBB,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                  0, 32'h0, 32'h0, 1'b1, 1'b0};
        vt[6] = '{2,  '{8'hFF,8'hFF,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                  0, 32'h0, 32'h0, 1'b0, 1'b1};

        Reset    = 1'b0;
        Rx_valid = 1'b0;
        Rx_data  = 8'h00;
        idle(2);
        chk("reset IM_we",    IM_we,    1'b0);
        chk("reset IM_addr",  IM_addr,  '0);
        chk("reset IM_wdata", IM_wdata, 32'h0);
        check_status("reset", 1'b0, 1'b0);
        Reset = 1'b1;
        idle(1);

        // Table vectors
        for (int v = 0; v < NV; v++) begin
            do_reset();
            stim.delete();
            for (int i = 0; i < vt[v].len; i++) stim.push_back(vt[v].b[i]);
            fixup_csum();
            send_stim(v % 2);
            idle(4);
            chk($sformatf("tv%0d nwr", v), wr_q.size(), vt[v].nw);
            if (vt[v].nw > 0 && wr_q.size() > 0) begin
                chk($sformatf("tv%0d w0 addr", v), wr_q[0].addr, 0);
                chk($sformatf("tv%0d w0 data", v), wr_q[0].data, vt[v].w0);
            end
            if (vt[v].nw > 1 && wr_q.size() > 1) begin
                chk($sformatf("tv%0d w1 addr", v), wr_q[1].addr, 1);
                chk($sformatf("tv%0d w1 data", v), wr_q[1].data, vt[v].w1);
            end
            check_status($sformatf("tv%0d", v), vt[v].done, vt[v].err);
        end

        // Timeout fires after exactly TO idle cycles; later bytes ignored
        do_reset();
        stim = '{8'h00, 8'h01, 8'h12, 8'h34};
        send_stim(0);
        idle(TO - 1);
        chk("to early Err", Err, 1'b0);
        idle(1);
        chk("to Err", Err, 1'b1);
        chk("to CPU_run", CPU_run, 1'b0);
        send_byte(8'h56);
        send_byte(8'h78);
        idle(3);
        chk("to nwr", wr_q.size(), 0);
        chk("to Err sticky", Err, 1'b1);

        // TO-1 idle cycles then the rest of the word is still accepted
        do_reset();
        stim = '{8'h00, 8'h01, 8'h12, 8'h34};
        send_stim(0);
        idle(TO - 1);
        send_byte(8'h56);
        send_byte(8'h78);
        idle(3);
        chk("to-1 Err", Err, 1'b0);
        chk("to-1 nwr", wr_q.size(), 1);
        if (wr_q.size() > 0) chk("to-1 data", wr_q[0].data, 32'h12345678);
`ifdef IM_LOADER_CHECKSUM_EN
        send_byte(8'h14);
        idle(3);
`endif
        chk("to-1 Done", Done, 1'b1);

        // Back-to-back N=3: bytes landing on write cycles are kept
        do_reset();
        stim = '{8'h00, 8'h03};
        for (int i = 0; i < 12; i++) stim.push_back(8'(8'h10 + 8'(i * 17)));
        fixup_csum();
        model_stream();
        send_stim(0);
        idle(4);
        check_writes("b2b");
        check_status("b2b", exp_done, exp_err);

        // Reset between bytes 6 and 7: one write kept, outputs cleared at once
        do_reset();
        stim = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
        send_stim(0);
        idle(2);
        #3 Reset = 1'b0;
        #1;
        chk("midrst IM_we",    IM_we,    1'b0);
        chk("midrst IM_addr",  IM_addr,  '0);
        chk("midrst IM_wdata", IM_wdata, 32'h0);
        check_status("midrst", 1'b0, 1'b0);
        chk("midrst nwr", wr_q.size(), 1);
        if (wr_q.size() > 0) begin
            chk("midrst addr", wr_q[0].addr, 0);
            chk("midrst data", wr_q[0].data, 32'h11223344);
        end
        @(negedge Clk);
        Reset = 1'b1;
        wr_q.delete();
        stim = '{8'h00, 8'h02, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h0B, 8'hAD, 8'hC0, 8'hDE};
        fixup_csum();
        model_stream();
        send_stim(1);
        idle(4);
        check_writes("fresh");
        check_status("fresh", exp_done, exp_err);

`ifdef IM_LOADER_CHECKSUM_EN
        // Wrong checksum aborts after the data has been written
        do_reset();
        stim = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
        send_stim(0);
        idle(4);
        chk("badcs nwr", wr_q.size(), 1);
        check_status("badcs", 1'b0, 1'b1);
`endif

        // N = 2^ADDR_W: full memory, address 0 written only once
        do_reset();
        stim = '{8'h04, 8'h00};
        for (int i = 0; i < 4 * (1 << AW); i++) stim.push_back(8'($urandom));
        fixup_csum();
        model_stream();
        send_stim(0);
        idle(4);
        check_writes("full");
        check_status("full", exp_done, exp_err);
        z = 0;
        foreach (wr_q[i]) if (wr_q[i].addr == 0) z++;
        chk("full addr0 writes", z, 1);

        // Randomized streams against the reference model
        for (int t = 0; t < 10; t++) begin
            do_reset();
            stim.delete();
            n = $urandom_range(1, 6);
            stim.push_back(8'h00);
            stim.push_back(8'(n));
            for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom));
            fixup_csum();
`ifdef IM_LOADER_CHECKSUM_EN
            if ($urandom_range(0, 3) == 0) stim[2 + 4 * n] = stim[2 + 4 * n] ^ 8'h01;
`endif
            model_stream();
            send_stim(2);
            idle(4);
            check_writes($sformatf("rnd%0d", t));
            check_status($sformatf("rnd%0d", t), exp_done, exp_err);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 Parameter ADDR_W, default 10: instruction-memory word-address width.
REQ-002 Parameter TIMEOUT, default 1000000: maximum Clk cycles between consecutive bytes once a load has started.
REQ-003 Clk  input  1  the single clock; all state changes on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Rx_valid  input  1  one-cycle strobe; Rx_data holds a received byte.
REQ-006 Rx_data  input  8  received byte, sampled only when Rx_valid=1.
REQ-007 IM_we  output  1  instruction-memory write strobe.
REQ-008 IM_addr  output  ADDR_W  instruction-memory word address.
REQ-009 IM_wdata  output  32  instruction word to write.
REQ-010 CPU_run  output  1  1 = the CPU may leave reset; 0 = hold the CPU in reset.
REQ-011 Done  output  1  the load completed successfully; sticky.
REQ-012 Err  output  1  the load was aborted; sticky.

Function
REQ-013 Byte stream format: COUNT_HI, COUNT_LO (16-bit word count N, big-endian), then 4*N data bytes, each word big-endian (first byte -> bits 31:24).
REQ-014 States: IDLE, CNT_LO, LOAD, DONE, ERR.
REQ-015 IDLE: a byte on Rx_valid is latched as COUNT_HI; the next state is CNT_LO.
REQ-016 CNT_LO: a byte is latched as COUNT_LO; if N=0, the next state is DONE; if N>2^ADDR_W, the next state is ERR; otherwise the next state is LOAD, with the word index and byte index cleared.
REQ-017 LOAD: each byte shifts into a 32-bit assembly register; on the 4th byte of a word, the byte index wraps to 0.
REQ-018 In the cycle after the 4th byte's Rx_valid, the block drives IM_we=1 for exactly one cycle, with IM_addr = the word index (starting at 0) and IM_wdata = the assembled word; the word index then increments.
REQ-019 A byte arriving during the IM_we cycle is accepted as the next word's first byte; no byte is lost.
REQ-020 After write N-1 completes, the next state is DONE.
REQ-021 When there is no Rx_valid for TIMEOUT consecutive cycles in CNT_LO or LOAD, the next state is ERR; the counter restarts on every accepted byte; IDLE never times out.
REQ-022 DONE: Done=1 and CPU_run=1; all further bytes are ignored.
REQ-023 ERR: Err=1 and CPU_run=0; all further bytes are ignored; the only exit is Reset.
REQ-024 IM_we=0 in every state except the single write cycle; IM_addr and IM_wdata hold their last values otherwise.
REQ-025 The word index is ADDR_W+1 bits wide, so N=2^ADDR_W completes with no alias on address 0.

Reset
REQ-026 With Reset=0, the state returns to IDLE immediately, regardless of clock.
REQ-027 On reset: IM_we=0, IM_addr=0, IM_wdata=0, CPU_run=0, Done=0, Err=0; all counters, the assembly register and the checksum are cleared.
REQ-028 Reset asserted mid-load aborts the load without a partial write; words already written remain in IM.

Configuration
REQ-029 Macro IM_LOADER_CHECKSUM_EN.
- Defined: after the last data byte, one extra byte is expected, equal to the 8-bit sum of all data bytes mod 256; a match goes to DONE, a mismatch goes to ERR, and TIMEOUT applies while waiting; N=0 also expects a checksum of 0x00.
- Not defined: there is no checksum byte, and DONE follows the last write directly.

Verification
REQ-030 Bytes 00 02 12 34 56 78 AA BB CC DD -> IM_we pulses at addr 0 with 0x12345678, then at addr 1 with 0xAABBCCDD; Done=1; CPU_run=1.
REQ-031 Bytes 00 00 -> DONE with no IM_we pulse (macro defined: bytes 00 00 00 -> DONE).
REQ-032 Bytes 04 01 with ADDR_W=10 -> Err=1, CPU_run=0, no IM_we; later bytes are ignored.
REQ-033 Bytes 00 01 12 34, then TIMEOUT idle cycles -> Err=1 and no write; with TIMEOUT-1 idle cycles followed by 56 78 -> a write of 0x12345678.
REQ-034 Back-to-back Rx_valid every cycle for N=3 -> 3 IM_we pulses with correct addresses; the byte landing on each IM_we cycle is retained.
REQ-035 Reset asserted between bytes 6 and 7 of an N=2 load -> outputs are at reset values; one write (addr 0) occurred; a fresh stream then loads correctly. With the macro defined and a wrong checksum -> Err=1.
